// File: rtl/hazard_scoreboard_pkg.sv
// Shared CPU definitions: forwarding-mux encodings, result-source codes and
// the control-resolution case used to expose the hazard decision.
package hazard_scoreboard_pkg;

    // Operand source selects for the E-stage ALU inputs
    localparam logic [1:0] FWD_RF = 2'b00;  // register file value
    localparam logic [1:0] FWD_W  = 2'b01;  // forwarded from writeback
    localparam logic [1:0] FWD_M  = 2'b10;  // forwarded from memory stage

    // ResultSrcE value marking a load in the execute stage
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    // Which priority case won this cycle
    typedef enum logic [2:0] {
        CTL_NONE,
        CTL_CACHE,
        CTL_REDIRECT,
        CTL_BRANCH,
        CTL_LOAD_USE
    } ctl_case_e;

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating event counter with synchronous clear.
// Precedence: rst, then clr, then increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count events, holding at all-ones once saturated
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding, load-use detection with an
// optional load shadow for slow loads, stall/flush/redirect resolution and
// performance counters. All hazard outputs are combinational; only the load
// shadow, the redirect-pending flag and the counters hold state.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int LOAD_EXTRA = 0,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [1:0]        ResultSrcE,
    input  logic [1:0]        PCSrcE,
    input  logic              CacheStall,
    input  logic              branch_mispredict_i,
    input  logic              PerfClr,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallFetch,
    output logic              StallDecode,
    output logic              StallExecute,
    output logic              StallMemory,
    output logic              StallWriteback,
    output logic              FlushDecode,
    output logic              FlushExecute,
    output logic              FlushWriteback,
    output logic              pc_redirect_o,
    output logic [CNT_W-1:0]  PerfStallCnt,
    output logic [CNT_W-1:0]  PerfFlushCnt,
    output logic [CNT_W-1:0]  PerfLoadUseCnt
);

    // x0 never creates a dependency
    function automatic logic reg_match(input logic [REG_AW-1:0] rs,
                                       input logic [REG_AW-1:0] rd);
        return (rs != '0) && (rs == rd);
    endfunction

    // Memory stage wins over writeback because it holds the younger result
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input logic [REG_AW-1:0] rd_m,
                                           input logic              we_m,
                                           input logic [REG_AW-1:0] rd_w,
                                           input logic              we_w);
        if (we_m && reg_match(rs, rd_m)) begin
            return FWD_M;
        end else if (we_w && reg_match(rs, rd_w)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    ctl_case_e ctl_case;
    logic      pending;
    logic      shadow_hit;
    logic      load_use;
    logic      ctl_flush;

    assign ForwardAE      = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE      = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    assign FlushWriteback = 1'b0;
    assign ctl_flush      = (ctl_case == CTL_REDIRECT) || (ctl_case == CTL_BRANCH);

    generate
        if (LOAD_EXTRA > 0) begin : g_shadow
            logic [LOAD_EXTRA-1:0] valid;
            logic [REG_AW-1:0]     rd [LOAD_EXTRA];
            logic                  push;
            logic                  hit;

            // A load-use bubble does not kill the load in E, only a control
            // flush does, so the load still enters the shadow while D stalls.
            assign push = (ResultSrcE == RESULT_LOAD) && (RdE != '0) && !ctl_flush;

            // Age in-flight loads one slot per cycle; hold them during a cache stall
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid <= '0;
                    for (int i = 0; i < LOAD_EXTRA; i++) rd[i] <= '0;
                end else if (!CacheStall) begin
                    valid[0] <= push;
                    rd[0]    <= push ? RdE : '0;
                    for (int i = 1; i < LOAD_EXTRA; i++) begin
                        valid[i] <= valid[i-1];
                        rd[i]    <= rd[i-1];
                    end
                end
            end

            // Any valid shadow entry whose result D still needs is a hazard
            always_comb begin
                hit = 1'b0;
                for (int i = 0; i < LOAD_EXTRA; i++) begin
                    if (valid[i] && (reg_match(Rs1D, rd[i]) || reg_match(Rs2D, rd[i])))
                        hit = 1'b1;
                end
            end

            assign shadow_hit = hit;
        end else begin : g_no_shadow
            assign shadow_hit = 1'b0;
        end
    endgenerate

    assign load_use = ((ResultSrcE == RESULT_LOAD) &&
                       (reg_match(Rs1D, RdE) || reg_match(Rs2D, RdE))) || shadow_hit;

    // Fixed-priority resolution: cache stall, redirect, taken branch, load-use
    always_comb begin
        ctl_case       = CTL_NONE;
        StallFetch     = 1'b0;
        StallDecode    = 1'b0;
        StallExecute   = 1'b0;
        StallMemory    = 1'b0;
        StallWriteback = 1'b0;
        FlushDecode    = 1'b0;
        FlushExecute   = 1'b0;
        pc_redirect_o  = 1'b0;
        if (CacheStall) begin
            ctl_case       = CTL_CACHE;
            StallFetch     = 1'b1;
            StallDecode    = 1'b1;
            StallExecute   = 1'b1;
            StallMemory    = 1'b1;
            StallWriteback = 1'b1;
        end else if (branch_mispredict_i || pending) begin
            ctl_case      = CTL_REDIRECT;
            pc_redirect_o = 1'b1;
            FlushDecode   = 1'b1;
            FlushExecute  = 1'b1;
        end else if (PCSrcE != 2'b00) begin
            ctl_case     = CTL_BRANCH;
            FlushDecode  = 1'b1;
            FlushExecute = 1'b1;
        end else if (load_use) begin
            ctl_case     = CTL_LOAD_USE;
            StallFetch   = 1'b1;
            StallDecode  = 1'b1;
            FlushExecute = 1'b1;
        end
    end

    // Remember a mispredict seen during a cache stall; it is consumed by the
    // first unstalled cycle, which also absorbs any new mispredict that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
        end else begin
            pending <= CacheStall && (pending || branch_mispredict_i);
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (PerfClr),
        .inc   (StallFetch),
        .count (PerfStallCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (PerfClr),
        .inc   (ctl_flush),
        .count (PerfFlushCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_load_use_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (PerfClr),
        .inc   (ctl_case == CTL_LOAD_USE),
        .count (PerfLoadUseCnt)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (LOAD_EXTRA = 2, CNT_W = 4).
// The driver applies one vector per cycle and queues its hand-computed
// expectation; a negedge monitor pops and compares.
module tb_hazard_scoreboard;

    localparam int AW = 5;
    localparam int CW = 4;
    localparam int HW = 13;
    localparam int W  = HW + 3 * CW;

    // Expected hazard word: {fa[1:0], fb[1:0], sf, sd, se, sm, sw, fd, fe, fw, redirect}
    localparam logic [HW-1:0] HZ_NONE = 13'b00_00_00000_000_0;
    localparam logic [HW-1:0] HZ_CS   = 13'b00_00_11111_000_0;
    localparam logic [HW-1:0] HZ_LU   = 13'b00_00_11000_010_0;
    localparam logic [HW-1:0] HZ_CTL  = 13'b00_00_00000_110_0;
    localparam logic [HW-1:0] HZ_RED  = 13'b00_00_00000_110_1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW;
    logic [1:0]    ResultSrcE, PCSrcE;
    logic          CacheStall, branch_mispredict_i, PerfClr;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallFetch, StallDecode, StallExecute, StallMemory, StallWriteback;
    logic          FlushDecode, FlushExecute, FlushWriteback, pc_redirect_o;
    logic [CW-1:0] PerfStallCnt, PerfFlushCnt, PerfLoadUseCnt;

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  mask_q[$];
    string         name_q[$];
    int            vectors;
    int            miscompares;

    hazard_scoreboard #(.REG_AW(AW), .LOAD_EXTRA(2), .CNT_W(CW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .Rs1D                (Rs1D),
        .Rs2D                (Rs2D),
        .Rs1E                (Rs1E),
        .Rs2E                (Rs2E),
        .RdE                 (RdE),
        .RdM                 (RdM),
        .RdW                 (RdW),
        .RegWriteM           (RegWriteM),
        .RegWriteW           (RegWriteW),
        .ResultSrcE          (ResultSrcE),
        .PCSrcE              (PCSrcE),
        .CacheStall          (CacheStall),
        .branch_mispredict_i (branch_mispredict_i),
        .PerfClr             (PerfClr),
        .ForwardAE           (ForwardAE),
        .ForwardBE           (ForwardBE),
        .StallFetch          (StallFetch),
        .StallDecode         (StallDecode),
        .StallExecute        (StallExecute),
        .StallMemory         (StallMemory),
        .StallWriteback      (StallWriteback),
        .FlushDecode         (FlushDecode),
        .FlushExecute        (FlushExecute),
        .FlushWriteback      (FlushWriteback),
        .pc_redirect_o       (pc_redirect_o),
        .PerfStallCnt        (PerfStallCnt),
        .PerfFlushCnt        (PerfFlushCnt),
        .PerfLoadUseCnt      (PerfLoadUseCnt)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [HW-1:0] hz_fwd(input logic [1:0] fa, input logic [1:0] fb);
        return {fa, fb, 9'b0};
    endfunction

    task automatic idle();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE = 2'b00; PCSrcE = 2'b00;
        CacheStall = 1'b0; branch_mispredict_i = 1'b0; PerfClr = 1'b0;
    endtask

    // Queue the expectation for the vector currently on the inputs, then
    // advance one cycle. Counter fields are compared only when chk is set.
    task automatic step(input string name, input logic [HW-1:0] hz, input bit chk,
                        input int sc, input int fc, input int lc);
        exp_q.push_back({hz, sc[CW-1:0], fc[CW-1:0], lc[CW-1:0]});
        mask_q.push_back({{HW{1'b1}}, chk ? {(3*CW){1'b1}} : {(3*CW){1'b0}}});
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one output observation per cycle
    always @(negedge clk) begin
        logic [W-1:0] act, expv, msk;
        string        nm;
        if (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            msk  = mask_q.pop_front();
            nm   = name_q.pop_front();
            act  = {ForwardAE, ForwardBE, StallFetch, StallDecode, StallExecute,
                    StallMemory, StallWriteback, FlushDecode, FlushExecute,
                    FlushWriteback, pc_redirect_o, PerfStallCnt, PerfFlushCnt,
                    PerfLoadUseCnt};
            vectors++;
            if ((act & msk) != (expv & msk)) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h (mask %h)", nm, act, expv, msk);
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Outputs stay combinational while reset is held; counters read 0
        Rs1E = 5; RdM = 5; RegWriteM = 1'b1;
        step("reset_fwd", hz_fwd(2'b10, 2'b00), 1, 0, 0, 0);
        rst = 1'b0;

        // Forwarding
        idle(); Rs1E = 5; RdM = 5; RegWriteM = 1'b1; RdW = 5; RegWriteW = 1'b1;
        step("fwd_m_over_w", hz_fwd(2'b10, 2'b00), 1, 0, 0, 0);
        Rs1E = 0;
        step("fwd_x0", HZ_NONE, 0, 0, 0, 0);
        idle(); Rs1E = 5; Rs2E = 9; RdM = 5; RdW = 5; RegWriteW = 1'b1;
        step("fwd_w_only", hz_fwd(2'b01, 2'b00), 0, 0, 0, 0);
        idle(); Rs1E = 3; Rs2E = 4; RdM = 4; RegWriteM = 1'b1; RdW = 3; RegWriteW = 1'b1;
        step("fwd_mixed", hz_fwd(2'b01, 2'b10), 1, 0, 0, 0);

        // Load to x0 is never a hazard
        idle(); ResultSrcE = 2'b01;
        step("lu_x0", HZ_NONE, 0, 0, 0, 0);

        // Load-use through E then two shadow slots: exactly 3 stall cycles
        idle(); ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
        step("lu_e", HZ_LU, 1, 0, 0, 0);
        idle(); Rs1D = 7;
        step("lu_shadow0", HZ_LU, 1, 1, 0, 1);
        step("lu_shadow1", HZ_LU, 1, 2, 0, 2);
        step("lu_done", HZ_NONE, 1, 3, 0, 3);
        idle(); PerfClr = 1'b1;
        step("clr_a", HZ_NONE, 1, 3, 0, 3);
        idle();
        step("clr_a_done", HZ_NONE, 1, 0, 0, 0);

        // Taken branch beats load-use; the squashed load leaves no shadow
        idle(); PCSrcE = 2'b01; ResultSrcE = 2'b01; RdE = 8; Rs2D = 8;
        step("br_over_lu", HZ_CTL, 1, 0, 0, 0);
        idle(); Rs2D = 8;
        step("br_no_shadow", HZ_NONE, 1, 0, 1, 0);

        // Shadow freezes during a cache stall
        idle(); ResultSrcE = 2'b01; RdE = 11;
        step("frz_load", HZ_NONE, 1, 0, 1, 0);
        idle(); CacheStall = 1'b1; Rs1D = 11;
        step("frz_cs1", HZ_CS, 0, 0, 0, 0);
        step("frz_cs2", HZ_CS, 0, 0, 0, 0);
        CacheStall = 1'b0;
        step("frz_hit0", HZ_LU, 0, 0, 0, 0);
        step("frz_hit1", HZ_LU, 0, 0, 0, 0);
        step("frz_done", HZ_NONE, 1, 4, 1, 2);
        idle(); PerfClr = 1'b1;
        step("clr_b", HZ_NONE, 1, 4, 1, 2);

        // Four-cycle cache stall, mispredict in cycle 2, redirect afterwards
        idle(); CacheStall = 1'b1;
        step("cs_1", HZ_CS, 1, 0, 0, 0);
        branch_mispredict_i = 1'b1;
        step("cs_2_mp", HZ_CS, 1, 1, 0, 0);
        branch_mispredict_i = 1'b0;
        step("cs_3", HZ_CS, 0, 0, 0, 0);
        step("cs_4", HZ_CS, 0, 0, 0, 0);
        idle();
        step("cs_redirect", HZ_RED, 1, 4, 0, 0);
        step("cs_after", HZ_NONE, 1, 4, 1, 0);

        // New mispredict in the cycle pending clears: one redirect only
        idle(); CacheStall = 1'b1; branch_mispredict_i = 1'b1;
        step("mp2_cs", HZ_CS, 0, 0, 0, 0);
        CacheStall = 1'b0;
        step("mp2_redirect", HZ_RED, 0, 0, 0, 0);
        idle();
        step("mp2_once", HZ_NONE, 1, 5, 2, 0);

        // Redirect outranks taken branch and load-use
        idle(); branch_mispredict_i = 1'b1; PCSrcE = 2'b10;
        ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
        step("red_prio", HZ_RED, 0, 0, 0, 0);
        idle(); Rs1D = 3;
        step("red_no_shadow", HZ_NONE, 1, 5, 3, 0);

        // Reset while a redirect is pending discards it
        idle(); CacheStall = 1'b1; branch_mispredict_i = 1'b1;
        step("rst_pend_set", HZ_CS, 0, 0, 0, 0);
        branch_mispredict_i = 1'b0; rst = 1'b1;
        step("rst_during_cs", HZ_CS, 0, 0, 0, 0);
        idle(); rst = 1'b0;
        step("rst_no_redirect", HZ_NONE, 1, 0, 0, 0);
        step("rst_quiet", HZ_NONE, 1, 0, 0, 0);

        // Saturation: 20 stall cycles on a 4-bit counter
        idle(); CacheStall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step($sformatf("sat_%0d", i), HZ_CS, 0, 0, 0, 0);
        end
        PerfClr = 1'b1;
        step("sat_full_clr", HZ_CS, 1, 15, 0, 0);
        idle();
        step("sat_cleared", HZ_NONE, 1, 0, 0, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
